mul_seq_ctrl: RTL and testbench

Byte-serial sequencer for the shared 8x16 multiplier.
- Accepts a command byte and three operand bytes over a valid/ready byte input.
- Drives the external multiplier operands and waits a fixed latency.
- Optionally accumulates the product into a 24-bit accumulator.
- Streams the 24-bit result out LSB-first over a valid/ready byte output.
- Sits between the chip's dedicated byte I/O and the multiplier datapath.

---
 rtl/mul_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_ctrl
// Description : Byte-serial sequencer for the shared 8x16 multiplier.
//               Collects a command byte plus three operand bytes over a
//               valid/ready byte input, drives the registered multiplier
//               operands, waits MUL_LATENCY cycles, optionally accumulates
//               the product into a 24-bit accumulator, and streams the
//               24-bit result LSB-first over a valid/ready byte output.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               in_data/in_valid/in_ready    - command/operand byte input
//               out_data/out_valid/out_ready - result byte output
//               out_last              - marks the third (MSB) result byte
//               mul_a, mul_b          - registered multiplier operands
//               mul_p                 - combinational multiplier product
//               busy                  - high in any state other than CMD
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl #(
  parameter int MUL_LATENCY = 1  // legal range 1..4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [7:0]  mul_a,
  output logic [15:0] mul_b,
  input  logic [23:0] mul_p,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_CMD    = 3'd0,
    S_OPA    = 3'd1,
    S_OPB_HI = 3'd2,
    S_OPB_LO = 3'd3,
    S_CALC   = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  localparam logic [2:0] C_LAT = 3'(MUL_LATENCY);

  // Command bit positions
  localparam int C_ACC   = 0;
  localparam int C_CLR   = 1;
  localparam int C_QUIET = 2;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [23:0] res_q, res_d;
  logic [23:0] acc_q, acc_d;
  logic [7:0]  mul_a_q, mul_a_d;
  logic [15:0] mul_b_q, mul_b_d;

  logic        w_in_fire;
  logic        w_out_fire;
  logic [23:0] w_base;
  logic [23:0] w_sum;

  // in_ready is a pure function of state so the producer never sees a
  // combinational path from its own in_valid back to in_ready.
  assign in_ready   = (state_q == S_CMD) || (state_q == S_OPA) ||
                      (state_q == S_OPB_HI) || (state_q == S_OPB_LO);
  assign out_valid  = (state_q == S_OUT);
  assign out_last   = (state_q == S_OUT) && (idx_q == 2'd2);
  assign busy       = (state_q != S_CMD);
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // CLR only zeroes the addend seen by this operation; the sum wraps mod 2^24.
  assign w_base = cmd_q[C_CLR] ? 24'd0 : acc_q;
  assign w_sum  = w_base + mul_p;

  always_comb begin
    out_data = 8'd0;
    if (state_q == S_OUT) begin
      case (idx_q)
        2'd0:    out_data = res_q[7:0];
        2'd1:    out_data = res_q[15:8];
        default: out_data = res_q[23:16];
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    res_d   = res_q;
    acc_d   = acc_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;

    case (state_q)
      S_CMD: begin
        if (w_in_fire) begin
          cmd_d   = in_data[2:0];
          state_d = S_OPA;
        end
      end
      S_OPA: begin
        if (w_in_fire) begin
          mul_a_d = in_data;
          state_d = S_OPB_HI;
        end
      end
      S_OPB_HI: begin
        if (w_in_fire) begin
          mul_b_d[15:8] = in_data;
          state_d       = S_OPB_LO;
        end
      end
      S_OPB_LO: begin
        if (w_in_fire) begin
          mul_b_d[7:0] = in_data;
          cnt_d        = C_LAT;
          state_d      = S_CALC;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - 3'd1;
        // Counter reaching 1 means mul_p has been stable for MUL_LATENCY cycles.
        if (cnt_q == 3'd1) begin
          res_d = cmd_q[C_ACC] ? w_sum : mul_p;
          if (cmd_q[C_ACC]) begin
            acc_d = w_sum;
          end
          idx_d   = 2'd0;
          state_d = cmd_q[C_QUIET] ? S_CMD : S_OUT;
        end
      end
      S_OUT: begin
        if (w_out_fire) begin
          if (idx_q == 2'd2) begin
            idx_d   = 2'd0;
            state_d = S_CMD;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = S_CMD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CMD;
      idx_q   <= 2'd0;
      cnt_q   <= 3'd0;
      cmd_q   <= 3'd0;
      res_q   <= 24'd0;
      acc_q   <= 24'd0;
      mul_a_q <= 8'd0;
      mul_b_q <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_ctrl
// Description : Self-checking bench for mul_seq_ctrl. Two instances run side
//               by side (MUL_LATENCY = 1 and 4); the bench plays the role of
//               the combinational multiplier and keeps an arithmetic model of
//               the accumulator to predict every result byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic [7:0]  in_data   [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  out_data  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        out_last  [2];
  logic [7:0]  mul_a     [2];
  logic [15:0] mul_b     [2];
  logic [23:0] mul_p     [2];
  logic        busy      [2];

  // Multiplier model: purely combinational product.
  assign mul_p[0] = {16'd0, mul_a[0]} * {8'd0, mul_b[0]};
  assign mul_p[1] = {16'd0, mul_a[1]} * {8'd0, mul_b[1]};

  mul_seq_ctrl #(.MUL_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst[0]),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_last(out_last[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]),
    .mul_p(mul_p[0]), .busy(busy[0])
  );

  mul_seq_ctrl #(.MUL_LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst(rst[1]),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_last(out_last[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]),
    .mul_p(mul_p[1]), .busy(busy[1])
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference accumulator per instance.
  logic [23:0] m_acc [2];

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected result of one operation from the arithmetic rules; updates model acc.
  task automatic model_op(int d, logic [7:0] cmd, logic [7:0] a, logic [15:0] b,
                          output logic [23:0] res);
    int unsigned prod;
    int unsigned base;
    int unsigned sum;
    prod = int'(a) * int'(b);
    base = cmd[1] ? 0 : int'(m_acc[d]);
    sum  = (base + prod) % (1 << 24);
    if (cmd[0]) begin
      m_acc[d] = sum[23:0];
      res      = sum[23:0];
    end else begin
      res = prod[23:0];
    end
  endtask

  task automatic put_byte(int d, logic [7:0] b);
    int k;
    k = 0;
    in_data[d]  = b;
    in_valid[d] = 1'b1;
    while (in_ready[d] !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 50) chk("in_ready_timeout", {31'd0, in_ready[d]}, 32'd1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic check_idle(int d, string tag);
    chk({tag, "_ovalid"}, {31'd0, out_valid[d]}, 32'd0);
    chk({tag, "_olast"},  {31'd0, out_last[d]},  32'd0);
    chk({tag, "_odata"},  {24'd0, out_data[d]},  32'd0);
    chk({tag, "_iready"}, {31'd0, in_ready[d]},  32'd1);
    chk({tag, "_busy"},   {31'd0, busy[d]},      32'd0);
  endtask

  task automatic do_reset(int d);
    rst[d]      = 1'b1;
    in_valid[d] = 1'b1;  // must be ignored during reset
    in_data[d]  = 8'($urandom);
    out_ready[d] = 1'b0;
    @(posedge clk); #1;
    rst[d]      = 1'b0;
    in_valid[d] = 1'b0;
    m_acc[d]    = 24'd0;
    check_idle(d, "rst");
    chk("rst_mula", {24'd0, mul_a[d]}, 32'd0);
    chk("rst_mulb", {16'd0, mul_b[d]}, 32'd0);
  endtask

  // Full operation: send four bytes, check CALC timing, drain result bytes.
  task automatic run_op(int d, logic [7:0] cmd, logic [7:0] a, logic [15:0] b,
                        int stall_idx, int stall_len, bit toggle);
    logic [23:0] exp_res;
    logic [7:0]  exp_byte;
    model_op(d, cmd, a, b, exp_res);
    put_byte(d, cmd);
    put_byte(d, a);
    put_byte(d, b[15:8]);
    put_byte(d, b[7:0]);
    chk("op_mula", {24'd0, mul_a[d]}, {24'd0, a});
    chk("op_mulb", {16'd0, mul_b[d]}, {16'd0, b});
    for (int i = 1; i <= lat_of(d); i++) begin
      chk("calc_ovalid", {31'd0, out_valid[d]}, 32'd0);
      chk("calc_iready", {31'd0, in_ready[d]}, 32'd0);
      chk("calc_busy",   {31'd0, busy[d]},     32'd1);
      if (toggle) begin
        in_valid[d] = 1'($urandom);
        in_data[d]  = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    in_valid[d] = 1'b0;
    if (cmd[2]) begin
      chk("quiet_ovalid", {31'd0, out_valid[d]}, 32'd0);
      chk("quiet_busy",   {31'd0, busy[d]},      32'd0);
      chk("quiet_iready", {31'd0, in_ready[d]},  32'd1);
    end else begin
      for (int idx = 0; idx < 3; idx++) begin
        exp_byte = exp_res[8*idx +: 8];
        chk("out_valid",  {31'd0, out_valid[d]}, 32'd1);
        chk("out_data",   {24'd0, out_data[d]},  {24'd0, exp_byte});
        chk("out_last",   {31'd0, out_last[d]},  (idx == 2) ? 32'd1 : 32'd0);
        chk("out_iready", {31'd0, in_ready[d]},  32'd0);
        if (idx == stall_idx) begin
          for (int s = 0; s < stall_len; s++) begin
            out_ready[d] = 1'b0;
            @(posedge clk); #1;
            chk("stall_valid",  {31'd0, out_valid[d]}, 32'd1);
            chk("stall_data",   {24'd0, out_data[d]},  {24'd0, exp_byte});
            chk("stall_iready", {31'd0, in_ready[d]},  32'd0);
          end
        end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
      end
      chk("done_ovalid", {31'd0, out_valid[d]}, 32'd0);
      chk("done_busy",   {31'd0, busy[d]},      32'd0);
    end
  endtask

  // Abort an operation with reset either after OPB_HI (stage 0) or after the
  // first output byte (stage 1).
  task automatic abort_op(int d, int stage);
    logic [23:0] dummy;
    put_byte(d, 8'h01);
    put_byte(d, 8'h11);
    put_byte(d, 8'h22);
    if (stage == 1) begin
      model_op(d, 8'h01, 8'h11, 16'h2233, dummy);
      put_byte(d, 8'h33);
      repeat (lat_of(d)) begin @(posedge clk); #1; end
      chk("abort_ovalid", {31'd0, out_valid[d]}, 32'd1);
      out_ready[d] = 1'b1;
      @(posedge clk); #1;
      out_ready[d] = 1'b0;
    end
    do_reset(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; in_data[d] = 8'd0; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      m_acc[d] = 24'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    check_idle(0, "init0");
    check_idle(1, "init1");

    // Plain multiply with a 5-cycle stall on the middle byte.
    run_op(0, 8'h00, 8'h12, 16'h3456, 1, 5, 1'b0);
    // Accumulate with clear, then accumulate again to force wrap.
    run_op(0, 8'h03, 8'hFF, 16'hFFFF, -1, 0, 1'b0);
    run_op(0, 8'h01, 8'hFF, 16'hFFFF, 2, 2, 1'b0);
    // Quiet accumulate with clear, then visible accumulate.
    run_op(0, 8'h07, 8'h02, 16'h0003, -1, 0, 1'b0);
    run_op(0, 8'h01, 8'h01, 16'h0001, 0, 1, 1'b0);

    // Latency-4 instance with in_valid toggling during CALC.
    run_op(1, 8'h00, 8'h12, 16'h3456, -1, 0, 1'b1);
    run_op(1, 8'hF9, 8'h05, 16'h0102, 1, 3, 1'b1);

    // Reset mid-operand and mid-output on both instances.
    for (int d = 0; d < 2; d++) begin
      run_op(d, 8'h03, 8'h40, 16'h1000, -1, 0, 1'b0);
      abort_op(d, 0);
      run_op(d, 8'h01, 8'h02, 16'h0003, -1, 0, 1'b0);
      abort_op(d, 1);
      run_op(d, 8'h00, 8'h02, 16'h0003, -1, 0, 1'b0);
      run_op(d, 8'h01, 8'h02, 16'h0003, -1, 0, 1'b0);
    end

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      run_op(n % 2, 8'($urandom), 8'($urandom), 16'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
